// File: rtl/baud_tick_nco.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : baud_tick_nco
// Brief    : UART baud generator built on a phase accumulator (NCO). Emits
//            single-cycle oversample, mid-bit and end-of-bit tick pulses with
//            a runtime-programmable fractional rate.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_nco #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int ACC_W        = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             sync,
    output logic [ACC_W-1:0] cur_inc,
    output logic             os_tick,
    output logic             mid_tick,
    output logic             bit_tick
);

    // Oversample counter width; never narrower than one bit.
    localparam int c_os_w = ($clog2(OVERSAMPLE) < 1) ? 1 : $clog2(OVERSAMPLE);

    // os_cnt value on the carry that produces the mid-bit and last-bit strobes.
    localparam logic [c_os_w-1:0] c_mid_cnt  = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0] c_last_cnt = c_os_w'(OVERSAMPLE - 1);

    // Rounded reset increment, computed wide so the 2^ACC_W product cannot overflow.
    localparam logic [63:0] c_default_inc_64 =
        (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_FREQ) / 64'd2)
        / 64'(CLK_FREQ);
    localparam logic [ACC_W-1:0] c_default_inc = c_default_inc_64[ACC_W-1:0];

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_cur_inc;
    logic [c_os_w-1:0] r_os_cnt;
    logic              r_os_tick;
    logic              r_mid_tick;
    logic              r_bit_tick;

    logic [ACC_W:0]    w_sum;
    logic              w_carry;

    // One extra bit on the add exposes the wrap as the oversample carry.
    always_comb begin
        w_sum   = {1'b0, r_acc} + {1'b0, r_cur_inc};
        w_carry = w_sum[ACC_W];
    end

    // Phase accumulator, oversample counter and registered tick strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cur_inc  <= c_default_inc;
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (cfg_load) begin
            // New rate: restart the bit phase from zero.
            r_cur_inc  <= cfg_inc;
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (sync) begin
            // Start-bit alignment: same rate, phase restarted.
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end else if (en) begin
            r_acc      <= w_sum[ACC_W-1:0];
            r_os_tick  <= w_carry;
            r_mid_tick <= w_carry && (r_os_cnt == c_mid_cnt);
            r_bit_tick <= w_carry && (r_os_cnt == c_last_cnt);
            if (w_carry) begin
                if (r_os_cnt == c_last_cnt) begin
                    r_os_cnt <= '0;
                end else begin
                    r_os_cnt <= r_os_cnt + c_os_w'(1);
                end
            end
        end else begin
            // Paused: phase is held, strobes are suppressed.
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
        end
    end

    assign cur_inc  = r_cur_inc;
    assign os_tick  = r_os_tick;
    assign mid_tick = r_mid_tick;
    assign bit_tick = r_bit_tick;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_nco.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_baud_tick_nco
// Brief    : Scoreboard bench for baud_tick_nco. Directed stimulus pushes the
//            hand-derived edge number of every expected tick; a monitor pops
//            and compares whenever the small instance emits a tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_tick_nco;

    logic       clk = 1'b0;
    logic       rst_n, en, cfg_load, sync;
    logic [7:0] cfg_inc, cur_inc;
    logic       os_tick, mid_tick, bit_tick;

    logic        d_rst_n;
    logic [23:0] d_cur_inc;
    logic        d_os, d_mid, d_bit;

    int cyc      = 0;
    int checks   = 0;
    int errors   = 0;
    int tick_cnt = 0;

    typedef struct {
        int cyc;
        bit mid;
        bit bt;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DEFAULT_INC for this instance: (9600*4*256 + 500000)/1000000 = 10
    baud_tick_nco #(
        .CLK_FREQ(1_000_000), .DEFAULT_BAUD(9600), .OVERSAMPLE(4), .ACC_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load), .cfg_inc(cfg_inc),
        .sync(sync), .cur_inc(cur_inc), .os_tick(os_tick), .mid_tick(mid_tick),
        .bit_tick(bit_tick)
    );

    // Default parameters: DEFAULT_INC = 25770
    baud_tick_nco dut_def (
        .clk(clk), .rst_n(d_rst_n), .en(1'b1), .cfg_load(1'b0), .cfg_inc(24'd0),
        .sync(1'b0), .cur_inc(d_cur_inc), .os_tick(d_os), .mid_tick(d_mid),
        .bit_tick(d_bit)
    );

    task automatic push(input int e, input bit m, input bit b);
        exp_t x;
        x.cyc = e;
        x.mid = m;
        x.bt  = b;
        q.push_back(x);
    endtask

    // Returns at the negedge whose driven inputs are sampled by edge e.
    task automatic at_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string name, input logic [7:0] exp_inc);
        chk({name, "_ticks"}, {29'd0, os_tick, mid_tick, bit_tick}, 32'd0);
        chk({name, "_inc"}, {24'd0, cur_inc}, {24'd0, exp_inc});
    endtask

    // Monitor: every tick from the small instance must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL tick_missing: got no tick at edge %0d, expected one", q[0].cyc);
                void'(q.pop_front());
            end
            if (os_tick || mid_tick || bit_tick) begin
                checks++;
                tick_cnt++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected: got os/mid/bit=%b%b%b at edge %0d, expected none",
                             os_tick, mid_tick, bit_tick, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || os_tick !== 1'b1 || mid_tick !== e.mid || bit_tick !== e.bt) begin
                        errors++;
                        $display("FAIL tick_match: got os/mid/bit=%b%b%b at edge %0d, expected 1%b%b at edge %0d",
                                 os_tick, mid_tick, bit_tick, cyc, e.mid, e.bt, e.cyc);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout at edge %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int L, S, P, H, R, E1, c0, n;
        rst_n    = 1'b0;
        en       = 1'b1;
        cfg_load = 1'b0;
        sync     = 1'b0;
        cfg_inc  = 8'd0;
        d_rst_n  = 1'b0;

        // Reset held for three edges with en high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("reset", 8'd10);
        end
        chk("default_inc", {8'd0, d_cur_inc}, 32'd25770);

        fork
            // Default-parameter rate over 40000 edges: floor(40000*25770/2^24)=61 carries, 3 bits.
            begin
                int os_n, b_n;
                os_n = 0;
                b_n  = 0;
                d_rst_n = 1'b1;
                repeat (40000) begin
                    @(negedge clk);
                    if (d_os)  os_n++;
                    if (d_bit) b_n++;
                end
                checks++;
                if (os_n < 60 || os_n > 62) begin
                    errors++;
                    $display("FAIL default_os_rate: got %0d expected 61 +/-1", os_n);
                end
                checks++;
                if (b_n < 2 || b_n > 4) begin
                    errors++;
                    $display("FAIL default_bit_rate: got %0d expected 3 +/-1", b_n);
                end
            end

            begin
                // Integer rate: inc=64 -> carry every 4th add, mid on 2nd, bit on 4th.
                rst_n = 1'b1; cfg_load = 1'b1; cfg_inc = 8'd64; en = 1'b1;
                L = cyc + 1;
                for (int k = 1; k <= 10; k++) push(L + 4*k, (k % 4) == 2, (k % 4) == 0);
                @(negedge clk);
                cfg_load = 1'b0;
                chk("load_inc", {24'd0, cur_inc}, 32'd64);
                at_edge(L + 42);

                // Sync mid-bit, then a 10-edge enable drop.
                cfg_load = 1'b1; cfg_inc = 8'd64;
                L = cyc + 1;
                for (int k = 1; k <= 5; k++) push(L + 4*k, (k % 4) == 2, (k % 4) == 0);
                @(negedge clk);
                cfg_load = 1'b0;
                S = L + 22;
                at_edge(S);
                sync = 1'b1;
                for (int j = 1; j <= 3; j++) push(S + 4*j, (j % 4) == 2, (j % 4) == 0);
                for (int j = 4; j <= 8; j++) push(S + 4*j + 10, (j % 4) == 2, (j % 4) == 0);
                @(negedge clk);
                sync = 1'b0;
                chk("sync_keeps_inc", {24'd0, cur_inc}, 32'd64);
                at_edge(S + 14);
                en = 1'b0;
                at_edge(S + 24);
                en = 1'b1;
                at_edge(S + 44);

                // Fractional rate: inc=96 -> carries at adds 3,6,8 of every 8.
                cfg_load = 1'b1; cfg_inc = 8'd96;
                L  = cyc + 1;
                c0 = tick_cnt;
                for (int k = 1; k <= 300; k++) begin
                    case ((k - 1) % 3)
                        0:       n = 3;
                        1:       n = 6;
                        default: n = 8;
                    endcase
                    push(L + 8*((k - 1) / 3) + n, (k % 4) == 2, (k % 4) == 0);
                end
                @(negedge clk);
                cfg_load = 1'b0;
                at_edge(L + 802);
                chk("frac_count", tick_cnt - c0, 32'd300);

                // cfg_load together with sync: load wins, phase cleared.
                cfg_load = 1'b1; sync = 1'b1; cfg_inc = 8'd128;
                P = cyc + 1;
                for (int k = 1; k <= 8; k++) push(P + 2*k, (k % 4) == 2, (k % 4) == 0);
                @(negedge clk);
                cfg_load = 1'b0; sync = 1'b0;
                chk("prio_inc", {24'd0, cur_inc}, 32'd128);
                at_edge(P + 17);

                // Halt: inc=0 gives no ticks.
                cfg_load = 1'b1; cfg_inc = 8'd0;
                H  = cyc + 1;
                c0 = tick_cnt;
                @(negedge clk);
                cfg_load = 1'b0;
                at_edge(H + 1000);
                chk("halt_count", tick_cnt - c0, 32'd0);
                chk("halt_inc", {24'd0, cur_inc}, 32'd0);

                // Reset mid-bit drops the tick that edge R+8 would have produced.
                cfg_load = 1'b1; cfg_inc = 8'd64;
                R = cyc + 1;
                push(R + 4, 1'b0, 1'b0);
                @(negedge clk);
                cfg_load = 1'b0;
                at_edge(R + 8);
                rst_n = 1'b0;
                @(negedge clk);
                chk_idle("midbit_reset", 8'd10);

                // Restart from acc=0 at inc=10: carries at adds 26, 52, 77, 103.
                rst_n = 1'b1;
                E1 = cyc + 1;
                push(E1 + 25,  1'b0, 1'b0);
                push(E1 + 51,  1'b1, 1'b0);
                push(E1 + 76,  1'b0, 1'b0);
                push(E1 + 102, 1'b0, 1'b1);
                at_edge(E1 + 104);
                cfg_load = 1'b1; cfg_inc = 8'd0;
                @(negedge clk);
                cfg_load = 1'b0;
                repeat (3) @(negedge clk);
                chk("queue_drained", q.size(), 32'd0);
            end
        join

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
